ofm_drain_11: RTL and testbench
===============================

// Module: ofm_drain_11
// PURPOSE
// - Downstream of the 1x1 PE array: captures each cycle's per-column partial-sum results (sum_valid/sum).
// - Queues the captured vectors, requantises each sum to OUT_WIDTH (round, shift, ReLU, saturate).
// - Serialises the results into a single valid/ready stream towards the OFM write path.
// - Absorbs bursts from the array while the OFM path stalls.
// PARAMETERS
// - COL        8   number of PE columns / sum lanes
// - OFM_WIDTH  32  width of one sum (sum_t), signed two's complement
// - OUT_WIDTH  8   width of requantised output, signed
// - SNAP_DEPTH 4   snapshot FIFO depth (power of 2, >=2)
// PORTS
// - clk        in   1             clock, rising edge
// - rstn       in   1             async active-low reset
// - sum_valid  in   COL           per-column result valid from PE array
// - sum        in   sum_t[COL]    per-column results
// - cfg_shift  in   5             arithmetic right shift, 0..31
// - cfg_relu   in   1             1 = clamp negatives to 0
// - ofm_valid  out  1             output word valid
// - ofm_ready  in   1             downstream accepts
// - ofm_data   out  OUT_WIDTH     requantised result
// - ofm_col    out  $clog2(COL)   source column of ofm_data
// - ofm_last   out  1             last set column of the current snapshot
// - busy       out  1             FIFO non-empty or DRAIN state
// - ovf_err    out  1             sticky: snapshot dropped on full FIFO
// BEHAVIOUR
// - Reset (async, rstn=0): all outputs 0, FIFO empty, state IDLE, work mask 0, ovf_err 0.
// - Capture:
//   - Any cycle with |sum_valid=1 pushes {sum_valid, sum} as one snapshot at the next edge.
//   - sum_valid=0 cycles push nothing.
// - Full: push while FIFO full and no pop in the same cycle -> snapshot dropped, ovf_err set.
//   - ovf_err clears only on reset.
// - Push and pop in the same cycle on a full FIFO -> both succeed, no drop.
// - FSM IDLE:
//   - FIFO non-empty -> pop head into work {mask, data}, go to DRAIN.
//   - ofm_valid=0 in IDLE.
// - FSM DRAIN:
//   - ofm_valid=1; ofm_col = lowest set bit of mask; ofm_data = requant(data[ofm_col]).
//   - ofm_last=1 when exactly one mask bit is set.
// - Handshake rules:
//   - On ofm_valid&ofm_ready, clear that mask bit.
//   - ofm_data/ofm_col/ofm_last stay stable while ofm_valid=1 and ofm_ready=0.
// - Mask empties after a handshake:
//   - FIFO non-empty -> pop next snapshot in the same edge, stay DRAIN. No bubble.
//   - Otherwise -> IDLE.
// - Latency: sum_valid at cycle N with FIFO empty and IDLE -> ofm_valid at N+2.
// - Throughput: 1 word/cycle with ofm_ready held at 1.
// - Requant, in order:
//   - t = sum + (cfg_shift ? 1<<(cfg_shift-1) : 0), computed in OFM_WIDTH+1 bits.
//   - t = t >>> cfg_shift.
//   - If cfg_relu and t<0, t = 0.
//   - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
// - cfg_shift/cfg_relu are static while busy=1; they are applied at output time, not capture time.
// - Stride masking happens upstream: mask bits pass through unchanged, so even-only masks drain 4 words.
// STRUCTURE
// - Package ru_pkg:
//   - sum_t (logic signed [OFM_WIDTH-1:0]).
//   - drain_state_e {IDLE, DRAIN}.
//   - Function requant(sum_t, shift, relu).
// - Sub-module snap_fifo: sync FIFO, width COL*(OFM_WIDTH+1), depth SNAP_DEPTH.
//   - Ports push/pop/full/empty.
//   - Simultaneous push+pop is legal when full.
// - Top level holds the FSM, work register, priority encoder and requant datapath.
// TESTING
// 1. Reset mid-DRAIN with ofm_valid=1 -> ofm_valid=0, busy=0, ovf_err=0 immediately (async).
// 2. One snapshot, sum_valid=8'hFF, sums 0..7, shift=0, relu=0, ready=1:
//    - 8 words, cols 0..7, data 0..7.
//    - ofm_last only on col 7.
//    - First valid 2 cycles after capture.
// 3. sum_valid=8'h55, sum[0]=-300, sum[2]=300, sum[4]=-5, sum[6]=255, shift=1, relu=1:
//    - cols 0,2,4,6 -> data 0,127,0,127.
// 4. relu=0, shift=4, sum=-24 (t=-16 -> -1) and sum=23 (t=31 -> 1) -> data -1 and 1.
// 5. ofm_ready=0, then 5 back-to-back snapshots (SNAP_DEPTH=4):
//    - Work register holds snapshot 1, FIFO holds 2..5; no drop, ovf_err stays 0.
//    - A 6th snapshot -> ovf_err=1 and snapshot 6 is never output.
//    - Release ready -> snapshots 1..5 output in order, busy falls after the final ofm_last.
// 6. ready=1, sum_valid=8'h81 every cycle:
//    - Steady 1 word/cycle, no bubble between snapshots.
//    - ofm_col alternates 0,7; FIFO occupancy grows by 1 every two cycles until full, then drops begin.

Source files
------------

// File: rtl/ofm_drain_11_pkg.sv
// Shared types and the requantisation function for the OFM drain path.
// The package name is ru_pkg; the file is named after the block that uses it.
package ru_pkg;

  localparam int COL        = 8;
  localparam int OFM_WIDTH  = 32;
  localparam int OUT_WIDTH  = 8;
  localparam int SNAP_DEPTH = 4;

  typedef logic signed [OFM_WIDTH-1:0] sum_t;

  typedef enum logic {
    IDLE,
    DRAIN
  } drain_state_e;

  localparam logic signed [OFM_WIDTH:0] Q_MAX = (OFM_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [OFM_WIDTH:0] Q_MIN = (OFM_WIDTH+1)'(-(2**(OUT_WIDTH-1)));

  // One guard bit keeps the rounding add from wrapping at the sum_t extremes.
  function automatic logic [OUT_WIDTH-1:0] requant(sum_t s, logic [4:0] shift, logic relu);
    logic signed [OFM_WIDTH:0] t;
    logic signed [OFM_WIDTH:0] rnd;
    rnd = (shift == 5'd0) ? '0 : ((OFM_WIDTH+1)'(1) << (shift - 5'd1));
    t   = {s[OFM_WIDTH-1], s} + rnd;
    t   = t >>> shift;
    if (relu && t[OFM_WIDTH]) t = '0;
    if (t > Q_MAX)      t = Q_MAX;
    else if (t < Q_MIN) t = Q_MIN;
    return t[OUT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/ofm_drain_11_snap_fifo.sv
// Synchronous snapshot FIFO; a push on a full FIFO is accepted only when
// the same edge also pops.
module snap_fifo #(
  parameter int WIDTH = 264,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ofm_drain_11.sv
// Captures per-column PE results, buffers them as snapshots and serialises
// the requantised set columns onto one valid/ready stream.
module ofm_drain_11
  import ru_pkg::*;
(
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [COL-1:0]                    sum_valid,
  input  logic [COL-1:0][OFM_WIDTH-1:0]     sum,
  input  logic [4:0]                        cfg_shift,
  input  logic                              cfg_relu,
  output logic                              ofm_valid,
  input  logic                              ofm_ready,
  output logic [OUT_WIDTH-1:0]              ofm_data,
  output logic [$clog2(COL)-1:0]            ofm_col,
  output logic                              ofm_last,
  output logic                              busy,
  output logic                              ovf_err
);

  localparam int CW = $clog2(COL);
  localparam int SW = COL * (OFM_WIDTH + 1);

  drain_state_e                  state;
  logic [COL-1:0]                work_mask;
  logic [COL-1:0][OFM_WIDTH-1:0] work_data;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [SW-1:0] fifo_wdata;
  logic [SW-1:0] fifo_rdata;

  logic [CW-1:0] lsb_col;
  logic          lsb_found;
  logic          single;
  logic          handshake;
  logic          drain_done;

  assign fifo_push  = |sum_valid;
  assign fifo_wdata = {sum_valid, sum};

  snap_fifo #(
    .WIDTH (SW),
    .DEPTH (SNAP_DEPTH)
  ) u_snap_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    lsb_col   = '0;
    lsb_found = 1'b0;
    for (int i = 0; i < COL; i++) begin
      if (work_mask[i] && !lsb_found) begin
        lsb_col   = CW'(i);
        lsb_found = 1'b1;
      end
    end
  end

  assign single     = (work_mask != '0) && ((work_mask & (work_mask - COL'(1))) == '0);
  assign handshake  = (state == DRAIN) && ofm_ready;
  assign drain_done = handshake && single;

  // The FIFO head is taken either from IDLE or on the last word of the current
  // snapshot, so back-to-back snapshots drain without a bubble.
  assign fifo_pop = !fifo_empty && ((state == IDLE) || drain_done);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      work_mask <= '0;
      work_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            {work_mask, work_data} <= fifo_rdata;
            state                  <= DRAIN;
          end
        end
        DRAIN: begin
          if (handshake) begin
            if (single) begin
              if (!fifo_empty) begin
                {work_mask, work_data} <= fifo_rdata;
              end else begin
                work_mask <= '0;
                state     <= IDLE;
              end
            end else begin
              work_mask[lsb_col] <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_err <= 1'b0;
    end else if (fifo_push && fifo_full && !fifo_pop) begin
      ovf_err <= 1'b1;
    end
  end

  // Requantisation happens at output time using the live cfg_shift/cfg_relu.
  assign ofm_valid = (state == DRAIN);
  assign ofm_col   = ofm_valid ? lsb_col : '0;
  assign ofm_last  = ofm_valid && single;
  assign ofm_data  = ofm_valid ? requant(sum_t'(work_data[lsb_col]), cfg_shift, cfg_relu) : '0;
  assign busy      = !fifo_empty || (state == DRAIN);

endmodule

// File: tb/tb_ofm_drain_11.sv
// Self-checking bench for ofm_drain_11: table vectors plus multi-cycle
// sequences, with output words matched against an expectation queue.
module tb_ofm_drain_11;
  import ru_pkg::*;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [7:0]           sum_valid;
  logic [7:0][31:0]     sum;
  logic [4:0]           cfg_shift;
  logic                 cfg_relu;
  logic                 ofm_valid;
  logic                 ofm_ready;
  logic [7:0]           ofm_data;
  logic [2:0]           ofm_col;
  logic                 ofm_last;
  logic                 busy;
  logic                 ovf_err;

  always #5 clk = ~clk;

  ofm_drain_11 dut (
    .clk       (clk),
    .rstn      (rstn),
    .sum_valid (sum_valid),
    .sum       (sum),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .ofm_valid (ofm_valid),
    .ofm_ready (ofm_ready),
    .ofm_data  (ofm_data),
    .ofm_col   (ofm_col),
    .ofm_last  (ofm_last),
    .busy      (busy),
    .ovf_err   (ovf_err)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] col;
    logic       last;
  } word_t;

  typedef struct packed {
    logic [7:0]       mask;
    logic [7:0][31:0] sums;
    logic [4:0]       shift;
    logic             relu;
    logic [7:0][7:0]  exp;
  } vec_t;

  word_t sb[$];
  vec_t  vecs[6];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  bit    hold_pending = 0;
  word_t held;
  bit    gap_check = 0;
  int    hs_prev = -1;

  always @(posedge clk) cyc++;

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_requant(longint s, int sh, bit relu);
    longint t;
    t = s + ((sh > 0) ? (longint'(1) << (sh - 1)) : 64'sd0);
    t = t >>> sh;
    if (relu && t < 0) t = 0;
    if (t > 127)  t = 127;
    if (t < -128) t = -128;
    return t[7:0];
  endfunction

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    word_t cur;
    word_t exp_w;
    cur = {ofm_data, ofm_col, ofm_last};
    if (!rstn) begin
      hold_pending = 0;
    end else begin
      if (hold_pending && ofm_valid) check_output("stall_hold", 32'(cur), 32'(held));
      if (ofm_valid && ofm_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("[TB] FAIL unexpected_word: got %0h, expected no output", cur);
        end else begin
          exp_w = sb.pop_front();
          check_output("ofm_word", 32'(cur), 32'(exp_w));
        end
        if (gap_check) begin
          if (hs_prev >= 0) check_output("no_bubble_gap", 32'(cyc - hs_prev), 32'd1);
          hs_prev = cyc;
        end
      end
      hold_pending = ofm_valid && !ofm_ready;
      held = cur;
    end
  end

  task automatic apply_stimulus(logic [7:0] mask, logic [7:0][31:0] sums);
    sum_valid = mask;
    sum       = sums;
    @(posedge clk); #1;
    sum_valid = '0;
    sum       = '0;
  endtask

  task automatic push_expect_model(logic [7:0] mask, logic [7:0][31:0] sums, int sh, bit relu);
    for (int c = 0; c < 8; c++) begin
      if (mask[c]) sb.push_back({ref_requant(longint'($signed(sums[c])), sh, relu), 3'(c),
                                 ((mask >> (c + 1)) == 8'd0)});
    end
  endtask

  task automatic push_expect_table(logic [7:0] mask, logic [7:0][7:0] exp);
    for (int c = 0; c < 8; c++) begin
      if (mask[c]) sb.push_back({exp[c], 3'(c), ((mask >> (c + 1)) == 8'd0)});
    end
  endtask

  task automatic wait_drain(int budget, string name);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    n_vec++;
    if (sb.size() != 0 || busy) begin
      n_err++;
      $display("[TB] FAIL %s: drain timeout, %0d words pending, busy=%0b", name, sb.size(), busy);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0][31:0] s;

    foreach (vecs[i]) vecs[i] = '0;
    vecs[0].mask = 8'hFF;
    for (int c = 0; c < 8; c++) begin
      vecs[0].sums[c] = 32'(c);
      vecs[0].exp[c]  = 8'(c);
    end
    vecs[1].mask = 8'h55; vecs[1].shift = 5'd1; vecs[1].relu = 1'b1;
    vecs[1].sums[0] = -300; vecs[1].sums[2] = 300; vecs[1].sums[4] = -5; vecs[1].sums[6] = 255;
    vecs[1].exp[0] = 8'd0; vecs[1].exp[2] = 8'd127; vecs[1].exp[4] = 8'd0; vecs[1].exp[6] = 8'd127;
    vecs[2].mask = 8'h03; vecs[2].shift = 5'd4;
    vecs[2].sums[0] = -24; vecs[2].sums[1] = 23;
    vecs[2].exp[0] = 8'hFF; vecs[2].exp[1] = 8'h01;
    vecs[3].mask = 8'h80;
    vecs[3].sums[7] = -1000; vecs[3].exp[7] = 8'h80;
    vecs[4].mask = 8'h24; vecs[4].shift = 5'd31;
    vecs[4].sums[2] = 32'h7FFF_FFFF; vecs[4].sums[5] = 32'h8000_0000;
    vecs[4].exp[2] = 8'h01; vecs[4].exp[5] = 8'hFF;
    vecs[5].mask = 8'h18; vecs[5].relu = 1'b1;
    vecs[5].sums[3] = 128; vecs[5].sums[4] = -128;
    vecs[5].exp[3] = 8'd127; vecs[5].exp[4] = 8'd0;

    rstn = 1'b0; ofm_ready = 1'b1; sum_valid = '0; sum = '0;
    cfg_shift = '0; cfg_relu = 1'b0;
    #12;
    check_output("rst_ofm_valid", 32'(ofm_valid), 32'd0);
    check_output("rst_ofm_data",  32'(ofm_data),  32'd0);
    check_output("rst_ofm_col",   32'(ofm_col),   32'd0);
    check_output("rst_ofm_last",  32'(ofm_last),  32'd0);
    check_output("rst_busy",      32'(busy),      32'd0);
    check_output("rst_ovf_err",   32'(ovf_err),   32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Table vectors: single snapshots from an idle, empty drain.
    for (int v = 0; v < 6; v++) begin
      cfg_shift = vecs[v].shift;
      cfg_relu  = vecs[v].relu;
      push_expect_table(vecs[v].mask, vecs[v].exp);
      apply_stimulus(vecs[v].mask, vecs[v].sums);
      check_output("latency_n1_valid", 32'(ofm_valid), 32'd0);
      @(posedge clk); #1;
      check_output("latency_n2_valid", 32'(ofm_valid), 32'd1);
      wait_drain(40, "table_drain");
    end

    // Stalled output: five snapshots fit (work + 4 deep), the sixth drops.
    cfg_shift = 5'd0; cfg_relu = 1'b0; ofm_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      s = '0;
      s[0] = 32'(k * 16);
      s[1] = 32'(k * 16 + 1);
      push_expect_model(8'h03, s, 0, 1'b0);
      apply_stimulus(8'h03, s);
    end
    repeat (2) begin @(posedge clk); #1; end
    check_output("stall_ovf_before", 32'(ovf_err), 32'd0);
    check_output("stall_busy",       32'(busy),    32'd1);
    check_output("stall_valid",      32'(ofm_valid), 32'd1);
    check_output("stall_head_data",  32'(ofm_data), 32'd16);
    s = '0; s[0] = 32'd100; s[1] = 32'd101;
    apply_stimulus(8'h03, s);
    check_output("stall_ovf_after", 32'(ovf_err), 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    ofm_ready = 1'b1;
    wait_drain(60, "stall_drain");
    check_output("ovf_sticky", 32'(ovf_err), 32'd1);

    // Asynchronous reset in the middle of a drain.
    ofm_ready = 1'b0;
    s = '0;
    for (int c = 0; c < 8; c++) s[c] = 32'(c + 40);
    apply_stimulus(8'hFF, s);
    @(posedge clk); #1;
    check_output("mid_drain_valid", 32'(ofm_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check_output("async_rst_valid", 32'(ofm_valid), 32'd0);
    check_output("async_rst_busy",  32'(busy),      32'd0);
    check_output("async_rst_ovf",   32'(ovf_err),   32'd0);
    check_output("async_rst_last",  32'(ofm_last),  32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    ofm_ready = 1'b1;
    sb.delete();
    @(posedge clk); #1;

    // Back-to-back two-column snapshots: FIFO fills, ninth snapshot drops.
    gap_check = 1; hs_prev = -1;
    for (int k = 1; k <= 9; k++) begin
      s = '0;
      s[0] = 32'(k * 10);
      s[7] = 32'(k * 10 + 7);
      if (k == 9) check_output("burst_ovf_before", 32'(ovf_err), 32'd0);
      if (k <= 8) push_expect_model(8'h81, s, 0, 1'b0);
      apply_stimulus(8'h81, s);
    end
    check_output("burst_ovf_after", 32'(ovf_err), 32'd1);
    wait_drain(60, "burst_drain");
    gap_check = 0;

    check_output("final_valid", 32'(ofm_valid), 32'd0);
    check_output("final_busy",  32'(busy),      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
